// File: rtl/fnd_digit_scanner.sv
// fnd_digit_scanner: time-multiplexed N-digit 7-segment scan driver.
// A prescaler steps a digit index round-robin; every clock the selected digit's
// value nibble and its one-hot select are registered out toward the decoder.
// Optional leading-zero blanking is compiled in with `define FND_SCAN_BLANK_EN.
module fnd_digit_scanner #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned VALUE_W          = 4,
    parameter int unsigned CLK_DIV          = 100000,
    parameter int unsigned DIGIT_ACTIVE_LOW = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic [NUM_DIGITS*VALUE_W-1:0]   i_values,
    output logic [NUM_DIGITS-1:0]           o_digit_sel,
    output logic [VALUE_W-1:0]              o_value,
    output logic [$clog2(NUM_DIGITS)-1:0]   o_digit_idx,
    output logic                            o_tick
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF =
        (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]      prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [VALUE_W-1:0]    value_q, value_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic                  tick_q, tick_d;

    logic                  terminal;
    logic [VALUE_W-1:0]    value_sel;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  blank;

    // Pick the current digit's value nibble and its one-hot position
    always_comb begin
        value_sel = '0;
        onehot    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                value_sel = i_values[i*VALUE_W +: VALUE_W];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef FND_SCAN_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Most significant nonzero digit; digit 0 is the floor so it is never blanked
    always_comb begin
        msd = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (i_values[i*VALUE_W +: VALUE_W] != '0) begin
                msd = IDX_W'(i);
            end
        end
        blank = (idx_q > msd);
    end
`else
    assign blank = 1'b0;
`endif

    assign terminal = (prescaler_q == PRE_LAST);

    // Next-state for prescaler/index and the registered display outputs
    always_comb begin
        prescaler_d = prescaler_q;
        idx_d       = idx_q;
        digit_sel_d = SEL_OFF;
        value_d     = value_q;
        digit_idx_d = digit_idx_q;
        tick_d      = 1'b0;
        if (i_en) begin
            if (terminal) begin
                prescaler_d = '0;
                idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                tick_d      = 1'b1;
            end else begin
                prescaler_d = prescaler_q + 1'b1;
            end
            value_d     = value_sel;
            digit_idx_d = idx_q;
            if (!blank) begin
                digit_sel_d = (DIGIT_ACTIVE_LOW != 0) ? ~onehot : onehot;
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            digit_sel_q <= SEL_OFF;
            value_q     <= '0;
            digit_idx_q <= '0;
            tick_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            value_q     <= value_d;
            digit_idx_q <= digit_idx_d;
            tick_q      <= tick_d;
        end
    end

    assign o_digit_sel = digit_sel_q;
    assign o_value     = value_q;
    assign o_digit_idx = digit_idx_q;
    assign o_tick      = tick_q;

endmodule
